// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: shared FSM state type and active-low 7-segment constants
// (bit order g..a) for the binary-to-BCD display converter.
package bcd_seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: one BCD digit to active-low 7-segment code (g..a), with a
// blank override. Non-decimal codes show blank.
module seg7_dec
   import bcd_seg_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   // digit lookup; blank wins over the digit value
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_conv.sv
// bcd_display_conv: sequential binary-to-BCD converter (double dabble, one
// bit per cycle) driving DIGITS active-low 7-segment displays.
// Optional build macro LEADING_ZERO_BLANK_EN: blank zero digits above the
// most significant non-zero digit on hex_out (digit 0 always shown).
module bcd_display_conv
   import bcd_seg_pkg::*;
#(
   parameter int W      = 10,
   parameter int DIGITS = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [W-1:0]          bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   hex_out,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t          state;
   state_t          state_nxt;
   logic            accept;
   logic            last_shift;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    shreg;
   logic [BW-1:0]   scratch;
   logic [BW-1:0]   corr;
   logic [BW-1:0]   scratch_nxt;
   logic            ovf_acc;
   logic            shout;
   logic [DIGITS-1:0] blank;

   // next-state and control decode; start is only honoured in IDLE or DONE
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      last_shift = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (cnt == CNT_ONE) begin
               last_shift = 1'b1;
               state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register and shift counter
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= CNT_LOAD;
         end else if (state == ST_SHIFT) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   // one double-dabble step: add 3 to digits >= 5, then shift in next bin bit
   always_comb begin
      corr = scratch;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch[4*k +: 4] >= 4'd5) begin
            corr[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
         end
      end
      scratch_nxt = {corr[BW-2:0], shreg[W-1]};
      shout       = corr[BW-1];
   end

   // conversion datapath: operand shifter, BCD scratch and sticky overflow
   always_ff @(posedge Clock) begin
      if (accept) begin
         shreg   <= bin_in;
         scratch <= '0;
         ovf_acc <= 1'b0;
      end else if (state == ST_SHIFT) begin
         shreg   <= {shreg[W-2:0], 1'b0};
         scratch <= scratch_nxt;
         ovf_acc <= ovf_acc | shout;
      end
   end

   // result registers load on the final shift so they change with done
   always_ff @(posedge Clock) begin
      if (Reset) begin
         bcd_out  <= '0;
         overflow <= 1'b0;
      end else if (last_shift) begin
         bcd_out  <= scratch_nxt;
         overflow <= ovf_acc | shout;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // lz[k] is set when digits k..DIGITS-1 are all zero
   logic [DIGITS:0] lz;
   assign lz[DIGITS] = 1'b1;
   for (genvar g = 0; g < DIGITS; g++) begin : g_lz
      assign lz[g]    = lz[g+1] & (bcd_out[4*g +: 4] == 4'd0);
      assign blank[g] = (g != 0) & lz[g];
   end
`else
   assign blank = '0;
`endif

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_dec u_dec (
         .digit (bcd_out[4*g +: 4]),
         .blank (blank[g]),
         .seg   (hex_out[7*g +: 7])
      );
   end

endmodule

// File: tb/tb_bcd_display_conv.sv
// tb_bcd_display_conv: scoreboard bench for bcd_display_conv, with a
// 4-digit and a 3-digit instance (W=10) sharing clock and reset.
module tb_bcd_display_conv;

   localparam int W  = 10;
   localparam int D4 = 4;
   localparam int D3 = 3;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        start4, start3;
   logic [W-1:0] bin4, bin3;
   logic        busy4, done4, ovf4;
   logic        busy3, done3, ovf3;
   logic [15:0] bcd4;
   logic [27:0] hex4;
   logic [11:0] bcd3;
   logic [20:0] hex3;

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [27:0] bcd;
      logic        ovf;
      logic [48:0] hex;
   } exp_t;

   exp_t sb4[$];
   exp_t sb3[$];

   always #5 Clock = ~Clock;

   bcd_display_conv #(.W(W), .DIGITS(D4)) dut4 (
      .Clock(Clock), .Reset(Reset), .start(start4), .bin_in(bin4),
      .busy(busy4), .done(done4), .bcd_out(bcd4), .hex_out(hex4), .overflow(ovf4)
   );

   bcd_display_conv #(.W(W), .DIGITS(D3)) dut3 (
      .Clock(Clock), .Reset(Reset), .start(start3), .bin_in(bin3),
      .busy(busy3), .done(done3), .bcd_out(bcd3), .hex_out(hex3), .overflow(ovf3)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   // reference: decimal digits by division, overflow when value >= 10^nd
   function automatic exp_t model(input int val, input int nd);
      exp_t e;
      int   v;
      int   lim;
      bit   seen;
      e   = '0;
      v   = val;
      lim = 1;
      for (int k = 0; k < nd; k++) begin
         e.bcd[4*k +: 4] = 4'(v % 10);
         v   = v / 10;
         lim = lim * 10;
      end
      e.ovf = (val >= lim);
      seen  = 1'b0;
      for (int k = nd - 1; k >= 0; k--) begin
         if (e.bcd[4*k +: 4] != 4'd0) seen = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
         if (!seen && k != 0) e.hex[7*k +: 7] = 7'b1111111;
         else                 e.hex[7*k +: 7] = seg_of(e.bcd[4*k +: 4]);
`else
         e.hex[7*k +: 7] = seg_of(e.bcd[4*k +: 4]);
`endif
      end
      return e;
   endfunction

   task automatic wait_done4(output int lat);
      lat = 0;
      while (done4 !== 1'b1 && lat < 4*W) begin
         @(negedge Clock);
         lat++;
      end
   endtask

   task automatic wait_done3(output int lat);
      lat = 0;
      while (done3 !== 1'b1 && lat < 4*W) begin
         @(negedge Clock);
         lat++;
      end
   endtask

   task automatic test_reset;
      exp_t z4, z3;
      Reset = 1'b1; start4 = 1'b1; start3 = 1'b1; bin4 = 10'd77; bin3 = 10'd77;
      repeat (3) @(negedge Clock);
      z4 = model(0, D4);
      z3 = model(0, D3);
      checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL reset_ctrl4: busy=%b done=%b expected 0 0", busy4, done4); else passed++;
      checks++; if (bcd4 !== 16'h0 || ovf4 !== 1'b0) $display("FAIL reset_data4: bcd=%h ovf=%b expected 0000 0", bcd4, ovf4); else passed++;
      checks++; if (hex4 !== z4.hex[27:0]) $display("FAIL reset_hex4: got %h expected %h", hex4, z4.hex[27:0]); else passed++;
      checks++; if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h0 || ovf3 !== 1'b0) $display("FAIL reset_dut3: busy=%b done=%b bcd=%h ovf=%b expected 0 0 000 0", busy3, done3, bcd3, ovf3); else passed++;
      checks++; if (hex3 !== z3.hex[20:0]) $display("FAIL reset_hex3: got %h expected %h", hex3, z3.hex[20:0]); else passed++;
      Reset = 1'b0; start4 = 1'b0; start3 = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_max;
      int   lat;
      exp_t e;
      start4 = 1'b1; bin4 = 10'd1023; sb4.push_back(model(1023, D4));
      @(negedge Clock);
      start4 = 1'b0;
      checks++; if (busy4 !== 1'b1) $display("FAIL max_busy: got %b expected 1", busy4); else passed++;
      wait_done4(lat);
      // done visible in cycle t+W+1, i.e. after the W-th edge following acceptance
      checks++; if (lat != W) $display("FAIL max_latency: got %0d expected %0d", lat, W); else passed++;
      e = sb4.pop_front();
      checks++; if (bcd4 !== e.bcd[15:0] || bcd4 !== 16'h1023) $display("FAIL max_bcd: got %h expected 1023", bcd4); else passed++;
      checks++; if (ovf4 !== e.ovf) $display("FAIL max_ovf: got %b expected %b", ovf4, e.ovf); else passed++;
      checks++; if (hex4 !== e.hex[27:0]) $display("FAIL max_hex: got %h expected %h", hex4, e.hex[27:0]); else passed++;
      @(negedge Clock);
      checks++; if (done4 !== 1'b0 || busy4 !== 1'b0) $display("FAIL max_pulse: done=%b busy=%b expected 0 0", done4, busy4); else passed++;
   endtask

   task automatic test_zero;
      int          lat;
      exp_t        e;
      logic [27:0] lit;
`ifdef LEADING_ZERO_BLANK_EN
      lit = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
`else
      lit = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
      start4 = 1'b1; bin4 = 10'd0; sb4.push_back(model(0, D4));
      @(negedge Clock);
      start4 = 1'b0;
      wait_done4(lat);
      e = sb4.pop_front();
      checks++; if (lat != W) $display("FAIL zero_latency: got %0d expected %0d", lat, W); else passed++;
      checks++; if (bcd4 !== e.bcd[15:0] || ovf4 !== 1'b0) $display("FAIL zero_bcd: bcd=%h ovf=%b expected 0000 0", bcd4, ovf4); else passed++;
      checks++; if (hex4 !== lit) $display("FAIL zero_hex: got %h expected %h", hex4, lit); else passed++;
      @(negedge Clock);
   endtask

   task automatic test_values;
      int   vals[10];
      int   lat;
      exp_t e;
      vals = '{1, 9, 10, 99, 100, 305, 999, 0, 0, 0};
      for (int i = 7; i < 10; i++) vals[i] = int'($urandom_range(0, 1023));
      for (int i = 0; i < 10; i++) begin
         start4 = 1'b1; bin4 = 10'(vals[i]); sb4.push_back(model(vals[i], D4));
         @(negedge Clock);
         start4 = 1'b0;
         wait_done4(lat);
         checks++; if (lat != W) $display("FAIL val_latency[%0d]: got %0d expected %0d", vals[i], lat, W); else passed++;
         if (sb4.size() == 0) begin
            checks++; $display("FAIL val_queue[%0d]: scoreboard empty", vals[i]);
         end else begin
            e = sb4.pop_front();
            checks++; if (bcd4 !== e.bcd[15:0] || ovf4 !== e.ovf) $display("FAIL val_bcd[%0d]: got %h/%b expected %h/%b", vals[i], bcd4, ovf4, e.bcd[15:0], e.ovf); else passed++;
            checks++; if (hex4 !== e.hex[27:0]) $display("FAIL val_hex[%0d]: got %h expected %h", vals[i], hex4, e.hex[27:0]); else passed++;
         end
         // next start is issued in the DONE cycle: back-to-back restart
      end
      @(negedge Clock);
   endtask

   task automatic test_overflow;
      int   lat;
      exp_t e;
      start3 = 1'b1; bin3 = 10'd1000; sb3.push_back(model(1000, D3));
      @(negedge Clock);
      start3 = 1'b0;
      wait_done3(lat);
      e = sb3.pop_front();
      checks++; if (lat != W) $display("FAIL ovf_latency: got %0d expected %0d", lat, W); else passed++;
      checks++; if (ovf3 !== 1'b1 || ovf3 !== e.ovf) $display("FAIL ovf_set: got %b expected 1", ovf3); else passed++;
      checks++; if (bcd3 !== 12'h000 || bcd3 !== e.bcd[11:0]) $display("FAIL ovf_bcd: got %h expected 000", bcd3); else passed++;
      start3 = 1'b1; bin3 = 10'd999; sb3.push_back(model(999, D3));
      @(negedge Clock);
      start3 = 1'b0;
      wait_done3(lat);
      e = sb3.pop_front();
      checks++; if (ovf3 !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", ovf3); else passed++;
      checks++; if (bcd3 !== 12'h999 || hex3 !== e.hex[20:0]) $display("FAIL ovf_999: got %h/%h expected 999/%h", bcd3, hex3, e.hex[20:0]); else passed++;
      @(negedge Clock);
   endtask

   task automatic test_ignore_start;
      int          lat;
      int          extra;
      bit          stable;
      logic [15:0] prev;
      exp_t        e;
      prev   = bcd4;
      stable = 1'b1;
      start4 = 1'b1; bin4 = 10'd42; sb4.push_back(model(42, D4));
      @(negedge Clock);
      start4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 4*W) begin
         if (bcd4 !== prev) stable = 1'b0;
         start4 = (lat == 3);
         bin4   = (lat == 3) ? 10'd7 : 10'd42;
         @(negedge Clock);
         lat++;
      end
      start4 = 1'b0;
      e = sb4.pop_front();
      checks++; if (lat != W) $display("FAIL ign_latency: got %0d expected %0d", lat, W); else passed++;
      checks++; if (bcd4 !== e.bcd[15:0] || bcd4 !== 16'h0042) $display("FAIL ign_bcd: got %h expected 0042", bcd4); else passed++;
      checks++; if (stable !== 1'b1) $display("FAIL ign_hold: got %b expected 1", stable); else passed++;
      extra = 0;
      repeat (W + 3) begin
         @(negedge Clock);
         if (done4 === 1'b1) extra++;
      end
      checks++; if (extra != 0) $display("FAIL ign_extra_done: got %0d expected 0", extra); else passed++;
   endtask

   task automatic test_reset_abort;
      int extra;
      start4 = 1'b1; bin4 = 10'd123;
      @(negedge Clock);
      start4 = 1'b0;
      repeat (4) @(negedge Clock);
      // now inside the 5th SHIFT cycle
      checks++; if (busy4 !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", busy4); else passed++;
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL abort_ctrl: busy=%b done=%b expected 0 0", busy4, done4); else passed++;
      checks++; if (bcd4 !== 16'h0000) $display("FAIL abort_bcd: got %h expected 0000", bcd4); else passed++;
      extra = 0;
      repeat (W + 3) begin
         @(negedge Clock);
         if (done4 === 1'b1) extra++;
      end
      checks++; if (extra != 0) $display("FAIL abort_no_done: got %0d expected 0", extra); else passed++;
   endtask

   task automatic test_back_to_back;
      int   lat;
      int   gap;
      exp_t e;
      start4 = 1'b1; bin4 = 10'd5;
      for (int n = 0; n < 3; n++) sb4.push_back(model(5, D4));
      @(negedge Clock);
      wait_done4(lat);
      checks++; if (lat != W) $display("FAIL b2b_first: got %0d expected %0d", lat, W); else passed++;
      e = sb4.pop_front();
      checks++; if (bcd4 !== e.bcd[15:0]) $display("FAIL b2b_bcd0: got %h expected %h", bcd4, e.bcd[15:0]); else passed++;
      for (int n = 1; n < 3; n++) begin
         gap = 0;
         do begin
            @(negedge Clock);
            gap++;
         end while (done4 !== 1'b1 && gap < 4*W);
         if (n == 2) start4 = 1'b0;
         checks++; if (gap != W + 1) $display("FAIL b2b_period[%0d]: got %0d expected %0d", n, gap, W + 1); else passed++;
         e = sb4.pop_front();
         checks++; if (bcd4 !== e.bcd[15:0] || bcd4 !== 16'h0005) $display("FAIL b2b_bcd[%0d]: got %h expected 0005", n, bcd4); else passed++;
      end
      @(negedge Clock);
      checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL b2b_stop: busy=%b done=%b expected 0 0", busy4, done4); else passed++;
   endtask

   initial begin
      test_reset();
      test_max();
      test_zero();
      test_values();
      test_overflow();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
      $fatal(1, "watchdog");
   end

endmodule
